sync_hs_src: RTL and testbench

SYNC_HS_SRC -- requirements
Module: sync_hs_src

---
 rtl/sync_hs_pkg.sv | 27 ++
 rtl/hs_ack_sync.sv | 23 ++
 rtl/sync_hs_src.sv | 111 +++++++++++
 tb/tb_sync_hs_src.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_hs_pkg.sv
// rtl/sync_hs_pkg.sv - shared state encoding and default parameters for the handshake source
package sync_hs_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGE_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ_HI = 2'd1;
    localparam logic [1:0] ST_ACK_LO = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        REQ_HI = ST_REQ_HI,
        ACK_LO = ST_ACK_LO
    } hs_state_e;

    // Timeout counter is kept between 8 and 16 bits regardless of the limit.
    function automatic int to_cnt_w(input int lim);
        int w;
        w = $clog2(lim + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/hs_ack_sync.sv
// rtl/hs_ack_sync.sv - multi-flop synchronizer bringing the destination ack into clk_i
module hs_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_hs_src.sv
// rtl/sync_hs_src.sv - 4-phase req/ack source FSM; SYNC_HS_TIMEOUT_EN adds a sticky timeout_o
module sync_hs_src
    import sync_hs_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGE  = SYNC_STAGE_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              src_vld,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_rdy,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              busy_o
`ifdef SYNC_HS_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    hs_state_e state;
    logic      ack_s;
    logic      accept;

    hs_ack_sync #(
        .STAGES (SYNC_STAGE)
    ) u_ack_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (ack_i),
        .sync_o  (ack_s)
    );

    // A stale ack still high in IDLE blocks new words until it drops.
    assign src_rdy = (state == IDLE) & ~ack_s;
    assign accept  = src_vld & src_rdy;
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            req_o  <= 1'b0;
            data_o <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_o <= src_data;
                        req_o  <= 1'b1;
                        state  <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_o <= 1'b0;
                        state <= ACK_LO;
                    end
                end
                ACK_LO: begin
                    if (!ack_s) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    req_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SYNC_HS_TIMEOUT_EN
    localparam int              CNT_W   = to_cnt_w(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] to_cnt;
    logic             state_chg;

    assign state_chg = accept
                     | ((state == REQ_HI) & ack_s)
                     | ((state == ACK_LO) & ~ack_s);

    // The FSM keeps waiting after a timeout; only the flag records it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state_chg || (state == IDLE)) begin
                to_cnt <= '0;
            end else if (to_cnt != CNT_LIM) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (accept) begin
                timeout_o <= 1'b0;
            end else if (busy_o && !state_chg && (to_cnt == CNT_LIM - 1'b1)) begin
                timeout_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_hs_src.sv
// tb/tb_sync_hs_src.sv - self-checking bench for sync_hs_src (SYNC_HS_TIMEOUT_EN optional)
`timescale 1ns/1ps
module tb_sync_hs_src;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_vld;
    logic [DW-1:0] src_data;
    logic          src_rdy, req_o, done_o, busy_o;
    logic [DW-1:0] data_o;
    logic          ack_i, inst, ack_man;
`ifdef SYNC_HS_TIMEOUT_EN
    logic          timeout_o, timeout3;
`endif

    logic          vld3, rdy3, req3, ack3, done3, busy3;
    logic [DW-1:0] data3, dout3;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    int n_done_seen = 0, n_done_exp = 0, n_viol = 0;
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] got_q[$];
    logic          req_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    assign ack_i = inst ? req_o : ack_man;

    always #5 clk = ~clk;

    sync_hs_src #(.DATA_W(DW), .SYNC_STAGE(SS), .TIMEOUT_CYC(TO)) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .src_vld  (src_vld),
        .src_data (src_data),
        .src_rdy  (src_rdy),
        .req_o    (req_o),
        .data_o   (data_o),
        .ack_i    (ack_i),
        .done_o   (done_o),
        .busy_o   (busy_o)
`ifdef SYNC_HS_TIMEOUT_EN
        ,.timeout_o (timeout_o)
`endif
    );

    sync_hs_src #(.DATA_W(DW), .SYNC_STAGE(3), .TIMEOUT_CYC(TO)) u_dut3 (
        .clk_i    (clk),
        .rst_i    (rst),
        .src_vld  (vld3),
        .src_data (data3),
        .src_rdy  (rdy3),
        .req_o    (req3),
        .data_o   (dout3),
        .ack_i    (ack3),
        .done_o   (done3),
        .busy_o   (busy3)
`ifdef SYNC_HS_TIMEOUT_EN
        ,.timeout_o (timeout3)
`endif
    );

    // Transaction-level monitor: words seen at each req rise, done pulses, data stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_o && !req_prev) got_q.push_back(data_o);
            if (req_o && req_prev && data_o !== data_prev) n_viol++;
            if (done_o) n_done_seen++;
        end
        req_prev  = req_o;
        data_prev = data_o;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return req_o;
            1:       return done_o;
            2:       return req3;
            3:       return done3;
            4:       return src_rdy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic start(input logic [DW-1:0] d);
        chk1("rdy_before_accept", src_rdy, 1'b1);
        src_vld  = 1'b1;
        src_data = d;
        tick();
        src_vld = 1'b0;
        sent_q.push_back(d);
        chk1("req_rise", req_o, 1'b1);
        chkd("data_on_accept", data_o, d);
        chk1("busy_in_req", busy_o, 1'b1);
    endtask

    task automatic complete(input logic [DW-1:0] d, input int dly_hi, input int dly_lo);
        int n;
        repeat (dly_hi) tick();
        chk1("req_held", req_o, 1'b1);
        ack_man = 1'b1;
        wait_sig(0, 1'b0, 20, n);
        chkn("req_fall_latency", n, SS + 1);
        chkd("data_held", data_o, d);
        repeat (dly_lo) tick();
        chk1("no_early_done", done_o, 1'b0);
        ack_man = 1'b0;
        wait_sig(1, 1'b1, 20, n);
        chkn("done_latency", n, SS + 1);
        n_done_exp++;
        chk1("rdy_at_done", src_rdy, 1'b1);
        chk1("idle_at_done", busy_o, 1'b0);
        tick();
        chk1("done_single_cycle", done_o, 1'b0);
    endtask

    initial begin
        int n, prev;
        logic [DW-1:0] w;
        rst = 1'b1; src_vld = 1'b0; src_data = '0; inst = 1'b0; ack_man = 1'b0;
        vld3 = 1'b0; data3 = '0; ack3 = 1'b0;
        repeat (3) tick();
        chk1("rst_req", req_o, 1'b0);
        chkd("rst_data", data_o, '0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        tick();
        chk1("rdy_after_rst", src_rdy, 1'b1);

        // Single word, responder answers after 3 cycles.
        start(8'hA5);
        complete(8'hA5, 3, 3);

        // Three words back-to-back with src_vld held and an instant responder.
        inst = 1'b1;
        src_vld = 1'b1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            w = 8'(i + 1);
            src_data = w;
            wait_sig(4, 1'b1, 30, n);
            if (i > 0) chk1("done_coincides_rdy", done_o, 1'b1);
            tick();
            sent_q.push_back(w);
            chkd("b2b_data", data_o, w);
            chk1("b2b_req", req_o, 1'b1);
            if (i > 0) chkn("b2b_spacing", cyc - prev, 2 * (SS + 1) + 1);
            prev = cyc;
        end
        src_vld = 1'b0;
        wait_sig(1, 1'b1, 30, n);
        chkn("b2b_last_done", n, 2 * (SS + 1));
        n_done_exp += 3;
        tick();
        inst = 1'b0;

        // Stale ack held high before the request.
        ack_man = 1'b1;
        repeat (SS + 1) tick();
        src_vld = 1'b1;
        src_data = 8'h3C;
        repeat (4) tick();
        chk1("stale_rdy_low", src_rdy, 1'b0);
        chk1("stale_req_low", req_o, 1'b0);
        chk1("stale_busy_low", busy_o, 1'b0);
        ack_man = 1'b0;
        wait_sig(0, 1'b1, 20, n);
        src_vld = 1'b0;
        sent_q.push_back(8'h3C);
        chkn("stale_release_latency", n, SS + 1);
        chkd("stale_data", data_o, 8'h3C);
        complete(8'h3C, 1, 0);

        // Reset in the middle of REQ_HI abandons the word.
        start(8'h5A);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("async_rst_req", req_o, 1'b0);
        chk1("async_rst_busy", busy_o, 1'b0);
        chkd("async_rst_data", data_o, '0);
        chk1("async_rst_done", done_o, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk1("rdy_after_abandon", src_rdy, 1'b1);

        // Randomized words and responder delays.
        for (int k = 0; k < 8; k++) begin
            w = 8'($urandom);
            start(w);
            complete(w, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        // Three-stage synchronizer instance.
        vld3 = 1'b1;
        data3 = 8'hC3;
        tick();
        vld3 = 1'b0;
        chk1("ss3_req_rise", req3, 1'b1);
        repeat (2) tick();
        ack3 = 1'b1;
        wait_sig(2, 1'b0, 20, n);
        chkn("ss3_req_fall_latency", n, 4);
        chkd("ss3_data", dout3, 8'hC3);
        ack3 = 1'b0;
        wait_sig(3, 1'b1, 20, n);
        chkn("ss3_done_latency", n, 4);

`ifdef SYNC_HS_TIMEOUT_EN
        start(8'h77);
        repeat (TO - 1) tick();
        chk1("timeout_not_yet", timeout_o, 1'b0);
        tick();
        chk1("timeout_set", timeout_o, 1'b1);
        chk1("timeout_req_still_high", req_o, 1'b1);
        complete(8'h77, 0, 0);
        chk1("timeout_sticky", timeout_o, 1'b1);
        start(8'h88);
        chk1("timeout_cleared_on_accept", timeout_o, 1'b0);
        complete(8'h88, 0, 0);
`endif

        repeat (2) tick();
        chkn("sb_word_count", got_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
            chkd($sformatf("sb_word_%0d", i), got_q[i], sent_q[i]);
        chkn("done_pulse_count", n_done_seen, n_done_exp);
        chkn("data_change_while_req", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
